ps2_scancode_decoder: RTL
=========================

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 clrn  in  1  asynchronous active-low reset.
REQ-004 kb_data  in  8  scan-code byte at the head of the upstream keyboard receiver FIFO.
REQ-005 kb_ready  in  1  high while the upstream FIFO is non-empty.
REQ-006 kb_nextdata_n  out  1  registered, active-low pop strobe to the upstream FIFO.
REQ-007 key_code  out  8  last non-prefix make code.
REQ-008 key_ascii  out  8  ASCII of key_code, 0x00 if unmapped.
REQ-009 key_ext  out  1  last make code carried an E0 prefix.
REQ-010 key_valid  out  1  one-cycle pulse per decoded make event.
REQ-011 key_repeat  out  1  qualifies key_valid: typematic repeat of the held key.
REQ-012 key_pressed  out  1  level: the key in key_code/key_ext is held.
REQ-013 shift, ctrl, caps_lock  out  1 each  modifier state.
REQ-014 press_count  out  8  count of non-repeat, non-modifier make events.

Function
REQ-015 FSM states SHALL be IDLE, ACK, DECODE; IDLE->ACK when kb_ready=1; ACK->DECODE unconditionally; DECODE->IDLE unconditionally.
REQ-016 On the IDLE->ACK edge the block SHALL latch kb_data into an internal byte register.
REQ-017 kb_nextdata_n SHALL be 0 for exactly the one cycle spent in ACK and 1 in every other cycle.
REQ-018 In DECODE, byte 0xE0 SHALL set the ext flag, byte 0xF0 SHALL set the brk flag, with no other output change.
REQ-019 Prefix flags SHALL accumulate (E0 F0 xx = extended break), repeated prefixes SHALL be idempotent, and both flags SHALL clear after any non-prefix byte.
REQ-020 A non-prefix byte with brk=0 is a make; with brk=1 it is a break.
REQ-021 Make with ext=0, code 0x12 or 0x59 SHALL set the left/right shift bit; the matching break SHALL clear it; shift = OR of both bits.
REQ-022 Make of 0x14 (ext=0 left, ext=1 right) SHALL set the corresponding ctrl bit; the matching break SHALL clear it; ctrl = OR.
REQ-023 E0 12 and E0 59 (fake shifts) SHALL be ignored entirely.
REQ-024 Make of 0x58 with ext=0 SHALL toggle caps_lock only when it is not a repeat.
REQ-025 Modifier makes/breaks SHALL NOT pulse key_valid, change key_code, or change press_count.
REQ-026 Non-modifier make: register key_code, key_ext, key_ascii, set key_pressed=1, pulse key_valid in the cycle after DECODE.
REQ-027 key_repeat SHALL be 1 when the make equals the held key (same code and ext, key_pressed=1), else 0.
REQ-028 press_count SHALL increment by 1 on non-repeat non-modifier makes, wrapping 0xFF->0x00.
REQ-029 Break matching the held key SHALL clear key_pressed; any other break SHALL leave it unchanged and pulse nothing.
REQ-030 key_ascii per scan code set 2: a-z lowercase, uppercase when shift XOR caps_lock; 0-9 as digits regardless of shift; 0x29->0x20; 0x5A->0x0D; ext=1 or other codes ->0x00.
REQ-031 key_valid latency SHALL be 3 cycles after the first cycle kb_ready is seen high in IDLE; throughput one byte per 3 cycles.

Reset
REQ-032 clrn=0 SHALL immediately force state IDLE, kb_nextdata_n=1, all other outputs 0, prefix flags cleared, regardless of FSM state.
REQ-033 A byte latched but not yet decoded when reset asserts SHALL be discarded with no key_valid.

Verification
REQ-034 Byte 0x1C -> one ACK pop, key_valid=1 with key_code=0x1C, key_ascii=0x61, key_pressed=1, press_count=1.
REQ-035 Bytes 0x12, 0x1C, 0xF0 0x1C, 0xF0 0x12 -> key_ascii=0x41, shift 1 then 0, key_pressed 0, exactly one key_valid.
REQ-036 Bytes 0x58, 0xF0 0x58, 0x15 -> caps_lock=1, key_ascii=0x51; a repeated 0x58 0x58 toggles caps only once.
REQ-037 Bytes 0x1C 0x1C 0x1C -> three key_valid pulses, key_repeat 0,1,1, press_count=1; 256 distinct presses wrap press_count to 0.
REQ-038 Bytes 0xE0 0x12 0xE0 0x75 0xE0 0xF0 0x75 -> shift stays 0, key_ext=1, key_ascii=0x00, key_pressed ends 0.
REQ-039 clrn pulsed low during ACK -> kb_nextdata_n returns to 1 asynchronously, all outputs 0, no key_valid.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code set 2 decoder: pops bytes from the keyboard receiver FIFO,
// tracks E0/F0 prefixes and modifiers, and reports make events with ASCII.
module ps2_scancode_decoder (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    output logic       kb_nextdata_n,
    output logic [7:0] key_code,
    output logic [7:0] key_ascii,
    output logic       key_ext,
    output logic       key_valid,
    output logic       key_repeat,
    output logic       key_pressed,
    output logic       shift,
    output logic       ctrl,
    output logic       caps_lock,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {IDLE, ACK, DECODE} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       nextdata_n_q, nextdata_n_d;
    logic       ext_q, ext_d, brk_q, brk_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic       caps_q, caps_d, caps_held_q, caps_held_d;
    logic [7:0] key_code_q, key_code_d, key_ascii_q, key_ascii_d;
    logic       key_ext_q, key_ext_d, key_valid_q, key_valid_d;
    logic       key_repeat_q, key_repeat_d, key_pressed_q, key_pressed_d;
    logic [7:0] press_count_q, press_count_d;
    logic       is_make, same_key;

    function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
            8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
            8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
            8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
            8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;
            default: ch = 8'h00;
        endcase
        if (upper && ch >= 8'h61 && ch <= 8'h7A) begin
            ch = ch - 8'h20;
        end
        return ch;
    endfunction

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        nextdata_n_d  = 1'b1;
        ext_d         = ext_q;
        brk_d         = brk_q;
        lshift_d      = lshift_q;
        rshift_d      = rshift_q;
        lctrl_d       = lctrl_q;
        rctrl_d       = rctrl_q;
        caps_d        = caps_q;
        caps_held_d   = caps_held_q;
        key_code_d    = key_code_q;
        key_ascii_d   = key_ascii_q;
        key_ext_d     = key_ext_q;
        key_valid_d   = 1'b0;
        key_repeat_d  = 1'b0;
        key_pressed_d = key_pressed_q;
        press_count_d = press_count_q;
        is_make       = ~brk_q;
        same_key      = key_pressed_q && (byte_q == key_code_q) && (ext_q == key_ext_q);

        case (state_q)
            IDLE: begin
                if (kb_ready) begin
                    state_d      = ACK;
                    byte_d       = kb_data;
                    nextdata_n_d = 1'b0;
                end
            end
            ACK: state_d = DECODE;
            DECODE: begin
                state_d = IDLE;
                if (byte_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    if (byte_q == 8'h12 || byte_q == 8'h59) begin
                        // E0-prefixed shifts are emitted around nav keys and must not latch shift
                        if (!ext_q && byte_q == 8'h12) lshift_d = is_make;
                        if (!ext_q && byte_q == 8'h59) rshift_d = is_make;
                    end else if (byte_q == 8'h14) begin
                        if (ext_q) rctrl_d = is_make;
                        else       lctrl_d = is_make;
                    end else if (byte_q == 8'h58 && !ext_q) begin
                        // caps_held suppresses toggling on typematic repeats of caps lock
                        if (is_make && !caps_held_q) caps_d = ~caps_q;
                        caps_held_d = is_make;
                    end else if (is_make) begin
                        key_code_d    = byte_q;
                        key_ext_d     = ext_q;
                        key_ascii_d   = ext_q ? 8'h00 :
                                        scan_to_ascii(byte_q, (lshift_q | rshift_q) ^ caps_q);
                        key_pressed_d = 1'b1;
                        key_valid_d   = 1'b1;
                        key_repeat_d  = same_key;
                        if (!same_key) press_count_d = press_count_q + 8'd1;
                    end else if (same_key) begin
                        key_pressed_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q       <= IDLE;
            byte_q        <= 8'h00;
            nextdata_n_q  <= 1'b1;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            lshift_q      <= 1'b0;
            rshift_q      <= 1'b0;
            lctrl_q       <= 1'b0;
            rctrl_q       <= 1'b0;
            caps_q        <= 1'b0;
            caps_held_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ascii_q   <= 8'h00;
            key_ext_q     <= 1'b0;
            key_valid_q   <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_pressed_q <= 1'b0;
            press_count_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            nextdata_n_q  <= nextdata_n_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            lshift_q      <= lshift_d;
            rshift_q      <= rshift_d;
            lctrl_q       <= lctrl_d;
            rctrl_q       <= rctrl_d;
            caps_q        <= caps_d;
            caps_held_q   <= caps_held_d;
            key_code_q    <= key_code_d;
            key_ascii_q   <= key_ascii_d;
            key_ext_q     <= key_ext_d;
            key_valid_q   <= key_valid_d;
            key_repeat_q  <= key_repeat_d;
            key_pressed_q <= key_pressed_d;
            press_count_q <= press_count_d;
        end
    end

    assign kb_nextdata_n = nextdata_n_q;
    assign key_code      = key_code_q;
    assign key_ascii     = key_ascii_q;
    assign key_ext       = key_ext_q;
    assign key_valid     = key_valid_q;
    assign key_repeat    = key_repeat_q;
    assign key_pressed   = key_pressed_q;
    assign shift         = lshift_q | rshift_q;
    assign ctrl          = lctrl_q | rctrl_q;
    assign caps_lock     = caps_q;
    assign press_count   = press_count_q;

endmodule
